rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 2-bit output channel among four requesters.
//  It owns the select of the 4:1 2-bit-per-lane mux and presents the granted word as a valid/ready source.
//  Sits between four 2-bit producers and a single consumer.
// PARAMETERS
//  BURST_LEN  4  max consecutive transfers per grant; used only when RR_BURST_EN is defined (>=1)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  req        in   4  req[k]=1: requester k has a word pending
//  data       in   8  requester k word = data[2k+1:2k]; stable while req[k]=1 and not acked
//  out_ready  in   1  consumer accepts out_data this cycle
//  out_valid  out  1  out_data holds a valid word
//  out_data   out  2  word of the granted requester: data[2*sel+1:2*sel]
//  grant      out  4  one-hot granted requester, 0 when idle (registered)
//  sel        out  2  index of granted requester (registered); sel[0] = lsb
//  ack        out  4  grant & {4{out_valid & out_ready}}; combinational transfer pulse
// BEHAVIOUR
//  - Reset (clk edge with rst=1):
//    - state=IDLE, grant=0, sel=0, out_valid=0, ptr=0.
//    - ack=0 and out_data=data[1:0] follow combinationally.
//    - Wins over every other event, including a transfer in the same cycle.
//  - ptr (2 bits) = first index searched. Winner = first k with req[k]=1 in order ptr, ptr+1, ... (mod 4, wraps 3->0).
//  - IDLE:
//    - any req -> register winner into grant/sel, go GRANT.
//    - req seen at edge N -> out_valid=1 from cycle N+1.
//  - GRANT:
//    - out_valid=1; out_data is a pure mux of data by sel, with no added latency.
//  - Transfer = out_valid & out_ready.
//    - ack[sel]=1 that cycle.
//    - ptr <= sel+1 mod 4.
//    - Re-arbitrate in the same cycle from sel+1 using the current req.
//    - Any winner -> stay GRANT with the new grant/sel next cycle, giving back-to-back transfers (one per cycle).
//    - No winner -> IDLE, out_valid=0 next cycle.
//  - Still-asserted req of the acked requester counts as a new request (searched last).
//  - Backpressure (out_ready=0): grant, sel, out_valid held; ack=0.
//  - Abort: req[sel]=0 in GRANT without transfer -> IDLE next cycle, grant=0, out_valid=0, ptr unchanged.
//  - Transfer and req[sel] drop in the same cycle: the transfer completes (ack issued).
//  - grant is always one-hot or zero; out_valid=1 iff grant!=0.
// CONFIGURATION
//  RR_BURST_EN defined:
//    - 3-bit burst counter bcnt, reset 0.
//    - On a transfer, if req[sel] is still 1 and bcnt+1 < BURST_LEN: keep grant/sel, bcnt++, ptr unchanged.
//    - Otherwise rotate as above and set bcnt=0.
//    - bcnt=0 on abort and on every new grant.
//  RR_BURST_EN undefined:
//    - No counter; the grant rotates after every transfer.
//    - BURST_LEN is ignored.
// TESTING
//  1 rst=1 for 2 cycles, req=4'b1111 -> out_valid=0, grant=0, sel=0, ack=0 throughout.
//  2 After reset: req=4'b0100, data[5:4]=2'b10, out_ready=1.
//    -> next cycle grant=0100, sel=2, out_data=10, ack=0100; following cycle out_valid=0 once req drops.
//  3 req=4'b1111 held, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001, one per cycle, ack mirrors grant.
//  4 req=4'b0010, out_ready=0 for 3 cycles -> out_valid=1, grant=0010, out_data stable, ack=0.
//    -> out_ready=1 -> ack=0010 that cycle.
//  5 From reset: req=4'b0010 granted, out_ready=0, then req[1]->0 -> next cycle grant=0, out_valid=0.
//    -> then req=4'b0011 -> grant=0001 (ptr still 0).
//  6 RR_BURST_EN, BURST_LEN=2, req=4'b1111, out_ready=1 -> grants 0001,0001,0010,0010,0100,0100.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving one 2-bit valid/ready channel from four requesters.
// Define RR_BURST_EN to let a requester keep the grant for up to BURST_LEN transfers.
module rr_mux_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [7:0] data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] out_data,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [3:0] ack
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic       xfer;
    logic [1:0] arb_start;
    logic [1:0] win_idx;
    logic       win_found;
    logic       keep_burst;

    assign xfer     = out_valid & out_ready;
    assign ack      = grant & {4{xfer}};
    assign out_data = data[{sel, 1'b0} +: 2];

    // After a transfer the search restarts just past the served requester,
    // so it is only reconsidered once everyone else has been looked at.
    assign arb_start = (state == GRANT) ? sel + 2'd1 : ptr;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise an unassigned path infers a latch.
    always_comb begin : arb_search
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = arb_start;
        // Walk from the farthest candidate back to arb_start so the closest one wins.
        for (int i = 3; i >= 0; i--) begin
            idx = arb_start + 2'(i);
            if (req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

`ifdef RR_BURST_EN
    logic [2:0] bcnt;

    assign keep_burst = req[sel] && (int'(bcnt) + 1 < BURST_LEN);
`else
    logic unused_burst_len;

    // BURST_LEN has no effect without burst mode.
    assign keep_burst       = 1'b0;
    assign unused_burst_len = (BURST_LEN > 0);
`endif

    // NOTE: all state is written with non-blocking assignments so every
    // register samples values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
`ifdef RR_BURST_EN
            bcnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        grant     <= 4'b0001 << win_idx;
                        sel       <= win_idx;
                        out_valid <= 1'b1;
`ifdef RR_BURST_EN
                        bcnt      <= '0;
`endif
                    end
                end

                GRANT: begin
                    if (xfer) begin
                        if (keep_burst) begin
`ifdef RR_BURST_EN
                            bcnt <= bcnt + 3'd1;
`endif
                        end else begin
                            ptr <= sel + 2'd1;
`ifdef RR_BURST_EN
                            bcnt <= '0;
`endif
                            if (win_found) begin
                                grant <= 4'b0001 << win_idx;
                                sel   <= win_idx;
                            end else begin
                                state     <= IDLE;
                                grant     <= '0;
                                out_valid <= 1'b0;
                            end
                        end
                    end else if (!req[sel]) begin
                        // Requester withdrew before being served; ptr stays put.
                        state     <= IDLE;
                        grant     <= '0;
                        out_valid <= 1'b0;
`ifdef RR_BURST_EN
                        bcnt      <= '0;
`endif
                    end
                end

                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: per-cycle vector table with a
// scoreboard queue, plus a hand-written back-to-back sequence.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] data;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_data;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] ack;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       e_valid;
        logic [3:0] e_grant;
        logic [1:0] e_sel;
        logic       chk_sel;
        logic [3:0] e_ack;
        logic [1:0] e_data;
    } vec_t;

    vec_t       vecs[$];
    vec_t       exp_q[$];
    logic [3:0] grant_q[$];

    rr_mux_arbiter #(.BURST_LEN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .grant     (grant),
        .sel       (sel),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got %0d miscompares so far, required completion", n_err);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic rd,
                       input logic v, input logic [3:0] g, input logic [1:0] s,
                       input logic cs, input logic [3:0] a, input logic [1:0] d);
        vec_t x;
        x.rst = r; x.req = rq; x.rdy = rd;
        x.e_valid = v; x.e_grant = g; x.e_sel = s; x.chk_sel = cs;
        x.e_ack = a; x.e_data = d;
        vecs.push_back(x);
    endtask

    initial begin
        vec_t e;
        int   cycles;

        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        data      = 8'b11_10_01_00;   // lane k carries the value k

        //   rst req      rdy  valid grant    sel  chk  ack      data
        // reset held with all requests pending
        add(1, 4'b1111, 1,   0, 4'b0000, 2'd0, 1, 4'b0000, 2'b00);
        add(1, 4'b1111, 1,   0, 4'b0000, 2'd0, 1, 4'b0000, 2'b00);
        // single request, dropped in the transfer cycle
        add(0, 4'b0100, 1,   0, 4'b0000, 2'd0, 1, 4'b0000, 2'b00);
        add(0, 4'b0000, 1,   1, 4'b0100, 2'd2, 1, 4'b0100, 2'b10);
        add(0, 4'b0000, 1,   0, 4'b0000, 2'd0, 0, 4'b0000, 2'b00);
        // all requesting, streaming
        add(1, 4'b0000, 1,   0, 4'b0000, 2'd0, 0, 4'b0000, 2'b00);
        add(0, 4'b1111, 1,   0, 4'b0000, 2'd0, 1, 4'b0000, 2'b00);
`ifdef RR_BURST_EN
        add(0, 4'b1111, 1,   1, 4'b0001, 2'd0, 1, 4'b0001, 2'b00);
        add(0, 4'b1111, 1,   1, 4'b0001, 2'd0, 1, 4'b0001, 2'b00);
        add(0, 4'b1111, 1,   1, 4'b0010, 2'd1, 1, 4'b0010, 2'b01);
        add(0, 4'b1111, 1,   1, 4'b0010, 2'd1, 1, 4'b0010, 2'b01);
        add(0, 4'b1111, 1,   1, 4'b0100, 2'd2, 1, 4'b0100, 2'b10);
        add(1, 4'b0000, 0,   1, 4'b0100, 2'd2, 1, 4'b0000, 2'b10);
`else
        add(0, 4'b1111, 1,   1, 4'b0001, 2'd0, 1, 4'b0001, 2'b00);
        add(0, 4'b1111, 1,   1, 4'b0010, 2'd1, 1, 4'b0010, 2'b01);
        add(0, 4'b1111, 1,   1, 4'b0100, 2'd2, 1, 4'b0100, 2'b10);
        add(0, 4'b1111, 1,   1, 4'b1000, 2'd3, 1, 4'b1000, 2'b11);
        add(0, 4'b1111, 1,   1, 4'b0001, 2'd0, 1, 4'b0001, 2'b00);
        add(1, 4'b0000, 0,   1, 4'b0010, 2'd1, 1, 4'b0000, 2'b01);
`endif
        // backpressure for three cycles, then accept while the request drops
        add(0, 4'b0010, 0,   0, 4'b0000, 2'd0, 1, 4'b0000, 2'b00);
        add(0, 4'b0010, 0,   1, 4'b0010, 2'd1, 1, 4'b0000, 2'b01);
        add(0, 4'b0010, 0,   1, 4'b0010, 2'd1, 1, 4'b0000, 2'b01);
        add(0, 4'b0010, 0,   1, 4'b0010, 2'd1, 1, 4'b0000, 2'b01);
        add(0, 4'b0000, 1,   1, 4'b0010, 2'd1, 1, 4'b0010, 2'b01);
        add(0, 4'b0000, 0,   0, 4'b0000, 2'd0, 0, 4'b0000, 2'b00);
        // abort leaves ptr at 0
        add(1, 4'b0000, 0,   0, 4'b0000, 2'd0, 0, 4'b0000, 2'b00);
        add(0, 4'b0010, 0,   0, 4'b0000, 2'd0, 1, 4'b0000, 2'b00);
        add(0, 4'b0000, 0,   1, 4'b0010, 2'd1, 1, 4'b0000, 2'b01);
        add(0, 4'b0011, 0,   0, 4'b0000, 2'd0, 0, 4'b0000, 2'b00);
        add(0, 4'b0011, 0,   1, 4'b0001, 2'd0, 1, 4'b0000, 2'b00);
        // reset beats a same-cycle transfer: ptr must stay 0
        add(1, 4'b0011, 1,   1, 4'b0001, 2'd0, 1, 4'b0001, 2'b00);
        add(0, 4'b0011, 0,   0, 4'b0000, 2'd0, 1, 4'b0000, 2'b00);
        add(0, 4'b0011, 0,   1, 4'b0001, 2'd0, 1, 4'b0000, 2'b00);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            out_ready = vecs[i].rdy;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d out_valid", i), {3'b0, out_valid}, {3'b0, e.e_valid});
            check($sformatf("v%0d grant", i), grant, e.e_grant);
            check($sformatf("v%0d ack", i), ack, e.e_ack);
            if (e.chk_sel) begin
                check($sformatf("v%0d sel", i), {2'b0, sel}, {2'b0, e.e_sel});
                check($sformatf("v%0d out_data", i), {2'b0, out_data}, {2'b0, e.e_data});
            end
        end

        // Two requesters held high: acked requester is searched last.
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1001;
`ifdef RR_BURST_EN
        grant_q = '{4'b0001, 4'b0001, 4'b1000, 4'b1000};
`else
        grant_q = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
        cycles = 0;
        @(negedge clk);
        while (!out_valid && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        check("wait_valid", {3'b0, out_valid}, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] g;
            g = grant_q.pop_front();
            check($sformatf("b2b%0d grant", k), grant, g);
            check($sformatf("b2b%0d ack", k), ack, g);
            @(negedge clk);
        end
        req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
